// File: rtl/alu_exec_stage.sv
// Execute stage of the 5-stage pipeline: ALU-control decode, 32-bit ALU with
// zero flag and branch-target adder, registered into the EX/MEM boundary.
module alu_exec_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_ext_i,
  input  logic              alu_src_i,
  input  logic [2:0]        alu_op_i,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              zero_o,
  output logic [DATA_W-1:0] branch_target_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [3:0]        alu_ctl_o
);

  // ALU operation codes
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_XOR = 4'b0011;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_INV = 4'b1111;

  // Main-control ALU classes
  localparam logic [2:0] AOP_ADD  = 3'b000;
  localparam logic [2:0] AOP_SUB  = 3'b001;
  localparam logic [2:0] AOP_RTYP = 3'b010;
  localparam logic [2:0] AOP_AND  = 3'b011;
  localparam logic [2:0] AOP_OR   = 3'b100;
  localparam logic [2:0] AOP_SLT  = 3'b101;
  localparam logic [2:0] AOP_XOR  = 3'b110;

  logic [5:0]        funct;
  logic [3:0]        alu_ctl;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] br_tgt;

  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] branch_target_q, branch_target_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;

  assign funct = imm_ext_i[5:0];

  // Decode alu_op (and funct for R-type) into an ALU operation
  always_comb begin
    alu_ctl = CTL_INV;
    case (alu_op_i)
      AOP_ADD:  alu_ctl = CTL_ADD;
      AOP_SUB:  alu_ctl = CTL_SUB;
      AOP_AND:  alu_ctl = CTL_AND;
      AOP_OR:   alu_ctl = CTL_OR;
      AOP_SLT:  alu_ctl = CTL_SLT;
      AOP_XOR:  alu_ctl = CTL_XOR;
      AOP_RTYP: begin
        case (funct)
          6'b100000: alu_ctl = CTL_ADD;
          6'b100010: alu_ctl = CTL_SUB;
          6'b100100: alu_ctl = CTL_AND;
          6'b100101: alu_ctl = CTL_OR;
          6'b100110: alu_ctl = CTL_XOR;
          6'b100111: alu_ctl = CTL_NOR;
          6'b101010: alu_ctl = CTL_SLT;
          default:   alu_ctl = CTL_INV;
        endcase
      end
      default:  alu_ctl = CTL_INV;
    endcase
  end

  assign op_a = rs_data_i;
  assign op_b = alu_src_i ? imm_ext_i : rt_data_i;

  // ALU proper; arithmetic wraps, invalid ops yield 0
  always_comb begin
    result = '0;
    case (alu_ctl)
      CTL_AND: result = op_a & op_b;
      CTL_OR:  result = op_a | op_b;
      CTL_ADD: result = op_a + op_b;
      CTL_XOR: result = op_a ^ op_b;
      CTL_SUB: result = op_a - op_b;
      CTL_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTL_NOR: result = ~(op_a | op_b);
      default: result = '0;
    endcase
  end

  // Branch target is always computed, independent of the ALU class
  assign br_tgt = pc_plus4_i + {imm_ext_i[DATA_W-3:0], 2'b00};

  // Next-state: capture when enabled, otherwise hold (stall)
  always_comb begin
    alu_result_d    = alu_result_q;
    zero_d          = zero_q;
    branch_target_d = branch_target_q;
    store_data_d    = store_data_q;
    if (en_i) begin
      alu_result_d    = result;
      zero_d          = (result == '0);
      branch_target_d = br_tgt;
      store_data_d    = rt_data_i;
    end
  end

  // EX/MEM output register; reset value keeps zero consistent with result 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q    <= '0;
      zero_q          <= 1'b1;
      branch_target_q <= '0;
      store_data_q    <= '0;
    end else begin
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      branch_target_q <= branch_target_d;
      store_data_q    <= store_data_d;
    end
  end

  assign alu_result_o    = alu_result_q;
  assign zero_o          = zero_q;
  assign branch_target_o = branch_target_q;
  assign store_data_o    = store_data_q;
  assign alu_ctl_o       = alu_ctl;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases plus randomized vectors checked
// against an operation-level reference model with a held-output register model.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [31:0] alu_result, branch_target, store_data;
  logic        zero;
  logic [3:0]  alu_ctl;

  int n_chk = 0;
  int n_err = 0;

  // expected registered state
  logic [31:0] e_res, e_bt, e_sd;
  logic        e_zero;

  alu_exec_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en),
    .pc_plus4_i(pc_plus4), .rs_data_i(rs_data), .rt_data_i(rt_data),
    .imm_ext_i(imm_ext), .alu_src_i(alu_src), .alu_op_i(alu_op),
    .alu_result_o(alu_result), .zero_o(zero), .branch_target_o(branch_target),
    .store_data_o(store_data), .alu_ctl_o(alu_ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef enum int {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_INV} mop_e;

  // Which operation does the instruction ask for?
  function automatic mop_e pick_op(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'd0: return M_ADD;
      3'd1: return M_SUB;
      3'd3: return M_AND;
      3'd4: return M_OR;
      3'd5: return M_SLT;
      3'd6: return M_XOR;
      3'd2: begin
        if (fn == 6'd32) return M_ADD;
        if (fn == 6'd34) return M_SUB;
        if (fn == 6'd36) return M_AND;
        if (fn == 6'd37) return M_OR;
        if (fn == 6'd38) return M_XOR;
        if (fn == 6'd39) return M_NOR;
        if (fn == 6'd42) return M_SLT;
        return M_INV;
      end
      default: return M_INV;
    endcase
  endfunction

  function automatic logic [3:0] ctl_code(input mop_e m);
    logic [3:0] tbl [8];
    tbl = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC, 4'h7, 4'hF};
    return tbl[int'(m)];
  endfunction

  function automatic logic [31:0] calc(input mop_e m, input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (m)
      M_ADD: begin s = longint'(a) + longint'(b); return s[31:0]; end
      M_SUB: begin s = (longint'(1) << 32) + longint'(a) - longint'(b); return s[31:0]; end
      M_AND: return a & b;
      M_OR:  return a | b;
      M_XOR: return a ^ b;
      M_NOR: return ~(a | b);
      M_SLT: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // drive inputs (at negedge), check decoder, clock once, update model, check outputs
  task automatic step(input string tag, input logic e, input logic [2:0] op, input logic src,
                      input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] imm);
    mop_e        m;
    logic [31:0] r;
    longint unsigned bt;
    en = e; alu_op = op; alu_src = src; pc_plus4 = pc;
    rs_data = rs; rt_data = rt; imm_ext = imm;
    m = pick_op(op, imm[5:0]);
    r = calc(m, rs, src ? imm : rt);
    #1;
    chk({tag, ".ctl"}, {28'd0, alu_ctl}, {28'd0, ctl_code(m)});
    // before the edge the registered outputs must still show the old values
    chk({tag, ".pre"}, alu_result, e_res);
    @(posedge clk);
    #1;
    if (e) begin
      bt     = longint'(pc) + longint'(imm) * 4;
      e_res  = r;
      e_zero = (r == 32'd0);
      e_bt   = bt[31:0];
      e_sd   = rt;
    end
    chk({tag, ".res"},  alu_result,          e_res);
    chk({tag, ".zero"}, {31'd0, zero},       {31'd0, e_zero});
    chk({tag, ".bt"},   branch_target,       e_bt);
    chk({tag, ".sd"},   store_data,          e_sd);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] sweep_exp [7];
    logic [5:0]  sweep_fn  [7];
    logic [5:0]  valid_fn  [7];
    logic [31:0] rnd_imm, rnd_rs, rnd_rt;
    logic [2:0]  rnd_op;
    logic        rnd_src;

    sweep_fn  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
    valid_fn  = sweep_fn;
    sweep_exp = '{32'h1, 32'hFFFFFFFB, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h1};

    rst_n = 1'b0; en = 1'b0; alu_op = 3'd0; alu_src = 1'b0;
    pc_plus4 = 32'd0; rs_data = 32'd0; rt_data = 32'd0; imm_ext = 32'd0;
    e_res = 32'd0; e_zero = 1'b1; e_bt = 32'd0; e_sd = 32'd0;

    // reset state
    #12;
    chk("rst.res",  alu_result,          32'd0);
    chk("rst.zero", {31'd0, zero},       32'd1);
    chk("rst.bt",   branch_target,       32'd0);
    chk("rst.sd",   store_data,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) addi-style add
    step("t1", 1'b1, 3'b000, 1'b1, 32'h0, 32'h10, 32'h0, 32'h4);
    chk("t1.lit", alu_result, 32'h14);

    // 2) beq-style subtract of equal operands, negative branch offset
    step("t2", 1'b1, 3'b001, 1'b0, 32'h100, 32'h55, 32'h55, 32'hFFFFFFFF);
    chk("t2.lit_res", alu_result,    32'h0);
    chk("t2.lit_z",   {31'd0, zero}, 32'd1);
    chk("t2.lit_bt",  branch_target, 32'hFC);

    // 3) R-type funct sweep with literal expectations
    for (int i = 0; i < 7; i++) begin
      step($sformatf("t3.%0d", i), 1'b1, 3'b010, 1'b0, 32'h400, 32'hFFFFFFFE, 32'h3,
           {26'd0, sweep_fn[i]});
      chk($sformatf("t3.lit%0d", i), alu_result, sweep_exp[i]);
    end

    // 4) add wraps to zero; invalid funct
    step("t4a", 1'b1, 3'b000, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1);
    chk("t4a.lit", {alu_result[30:0], zero}, 32'd1);
    step("t4b", 1'b1, 3'b010, 1'b0, 32'h0, 32'h12345678, 32'h9, 32'h3F);
    chk("t4b.lit", {alu_result[27:0], alu_ctl}, 32'hF);

    // 5) stall holds outputs, then asynchronous reset mid-cycle
    step("t5a", 1'b1, 3'b100, 1'b0, 32'h2000, 32'hA0A0A0A0, 32'h0505, 32'h7);
    step("t5b", 1'b0, 3'b110, 1'b1, 32'h3000, 32'h11111111, 32'h22, 32'h44);
    step("t5c", 1'b0, 3'b001, 1'b0, 32'h5000, 32'h7, 32'h7, 32'h8);
    chk("t5.hold", alu_result, 32'hA0A0A5A5);
    en = 1'b1; rs_data = 32'h99; rt_data = 32'h1; alu_op = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    chk("t5.arst_res",  alu_result,    32'd0);
    chk("t5.arst_zero", {31'd0, zero}, 32'd1);
    chk("t5.arst_bt",   branch_target, 32'd0);
    chk("t5.arst_sd",   store_data,    32'd0);
    @(posedge clk); #1;
    chk("t5.rst_edge", alu_result, 32'd0);
    e_res = 32'd0; e_zero = 1'b1; e_bt = 32'd0; e_sd = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // 6) random vectors
    for (int i = 0; i < 1000; i++) begin
      rnd_op  = 3'($urandom_range(0, 7));
      rnd_src = 1'($urandom_range(0, 1));
      rnd_rs  = $urandom;
      rnd_rt  = ($urandom_range(0, 7) == 0) ? rnd_rs : $urandom;
      rnd_imm = $urandom;
      if ($urandom_range(0, 3) == 0) rnd_imm = rnd_imm & 32'hFF;
      if (rnd_op == 3'b010 && $urandom_range(0, 3) != 0)
        rnd_imm[5:0] = valid_fn[$urandom_range(0, 6)];
      if (rnd_src && $urandom_range(0, 7) == 0) rnd_rs = rnd_imm;
      step("rnd", ($urandom_range(0, 4) != 0), rnd_op, rnd_src, $urandom,
           rnd_rs, rnd_rt, rnd_imm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", n_err);
    $fatal(1);
  end

endmodule
